// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared memory port.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_arbiter_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8
);
    logic [NUM_PORTS-1:0]        iReq;
    logic [NUM_PORTS-1:0]        iWe;
    logic [NUM_PORTS*ADDR_W-1:0] iAddr;
    logic [NUM_PORTS*DATA_W-1:0] iWData;
    logic [NUM_PORTS-1:0]        oGrant;
    logic [NUM_PORTS-1:0]        oAck;
    logic [DATA_W-1:0]           oRData;
    logic                        oMemReq;
    logic                        oMemWe;
    logic [ADDR_W-1:0]           oMemAddr;
    logic [DATA_W-1:0]           oMemWData;
    logic [DATA_W-1:0]           iMemRData;
    logic                        oBusy;

    modport slave (
        input  iReq, iWe, iAddr, iWData, iMemRData,
        output oGrant, oAck, oRData, oMemReq, oMemWe, oMemAddr, oMemWData, oBusy
    );

    modport master (
        output iReq, iWe, iAddr, iWData, iMemRData,
        input  oGrant, oAck, oRData, oMemReq, oMemWe, oMemAddr, oMemWData, oBusy
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-port arbiter onto one fixed-latency memory port; one transaction in flight,
// fixed-priority or round-robin selection, all outputs registered.
module mem_arbiter #(
    parameter int unsigned NUM_PORTS    = 3,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MODE         = 0,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic          iClock,
    input  logic          iReset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t                state, stateN;
    logic [1:0]            cnt, cntN;
    logic [PW-1:0]         rrPtr, rrPtrN;
    logic [PW-1:0]         win, idxP;
    logic                  found;
    int unsigned           base, idx;

    logic [NUM_PORTS-1:0]  grantN, ackN;
    logic [DATA_W-1:0]     rDataN, memWDataN;
    logic [ADDR_W-1:0]     memAddrN;
    logic                  memReqN, memWeN, busyN;

    // Search begins one past the last winner in round-robin, at port 0 otherwise.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idxP  = '0;
        base  = (MODE == 1) ? (32'(rrPtr) + 1) : 0;
        if (base >= NUM_PORTS) base = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = base + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idxP = PW'(idx);
            if (!found && bus.iReq[idxP]) begin
                found = 1'b1;
                win   = idxP;
            end
        end
    end

    always_comb begin
        stateN    = state;
        cntN      = cnt;
        rrPtrN    = rrPtr;
        grantN    = bus.oGrant;
        ackN      = '0;
        rDataN    = bus.oRData;
        memReqN   = 1'b0;
        memWeN    = bus.oMemWe;
        memAddrN  = bus.oMemAddr;
        memWDataN = bus.oMemWData;
        case (state)
            IDLE: begin
                if (found) begin
                    stateN      = ISSUE;
                    grantN      = '0;
                    grantN[win] = 1'b1;
                    memReqN     = 1'b1;
                    memWeN      = bus.iWe[win];
                    memAddrN    = bus.iAddr[win*ADDR_W +: ADDR_W];
                    memWDataN   = bus.iWData[win*DATA_W +: DATA_W];
                    rrPtrN      = win;
                end
            end
            ISSUE: begin
                stateN = WAIT;
                cntN   = 2'(READ_LATENCY - 1);
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    stateN = ACK;
                    ackN   = bus.oGrant;
                    if (!bus.oMemWe) rDataN = bus.iMemRData;
                end else begin
                    cntN = cnt - 2'd1;
                end
            end
            ACK: begin
                stateN = IDLE;
                grantN = '0;
            end
            default: stateN = IDLE;
        endcase
        busyN = (stateN != IDLE);
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state         <= IDLE;
            cnt           <= '0;
            rrPtr         <= PW'(NUM_PORTS - 1);
            bus.oGrant    <= '0;
            bus.oAck      <= '0;
            bus.oRData    <= '0;
            bus.oMemReq   <= 1'b0;
            bus.oMemWe    <= 1'b0;
            bus.oMemAddr  <= '0;
            bus.oMemWData <= '0;
            bus.oBusy     <= 1'b0;
        end else begin
            state         <= stateN;
            cnt           <= cntN;
            rrPtr         <= rrPtrN;
            bus.oGrant    <= grantN;
            bus.oAck      <= ackN;
            bus.oRData    <= rDataN;
            bus.oMemReq   <= memReqN;
            bus.oMemWe    <= memWeN;
            bus.oMemAddr  <= memAddrN;
            bus.oMemWData <= memWDataN;
            bus.oBusy     <= busyN;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (fixed L=1, round-robin L=1, fixed L=3) share one
// stimulus; each is checked against hand-derived cycle-by-cycle expectations.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [7:0]  memRData;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8)) ifF ();
    mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8)) ifR ();
    mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8)) ifL ();

    assign ifF.iReq = req;  assign ifF.iWe = we;  assign ifF.iAddr = addr;
    assign ifF.iWData = wdata;  assign ifF.iMemRData = memRData;
    assign ifR.iReq = req;  assign ifR.iWe = we;  assign ifR.iAddr = addr;
    assign ifR.iWData = wdata;  assign ifR.iMemRData = memRData;
    assign ifL.iReq = req;  assign ifL.iWe = we;  assign ifL.iAddr = addr;
    assign ifL.iWData = wdata;  assign ifL.iMemRData = memRData;

    mem_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8), .MODE(0), .READ_LATENCY(1))
        dutF (.iClock(clk), .iReset(rst), .bus(ifF.slave));
    mem_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8), .MODE(1), .READ_LATENCY(1))
        dutR (.iClock(clk), .iReset(rst), .bus(ifR.slave));
    mem_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8), .MODE(0), .READ_LATENCY(3))
        dutL (.iClock(clk), .iReset(rst), .bus(ifL.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; memRData = '0;
        step(); step();
        chk("rst_grant", 48'(ifF.oGrant), 0);
        chk("rst_ack", 48'(ifF.oAck), 0);
        chk("rst_memreq", 48'(ifF.oMemReq), 0);
        chk("rst_busy", 48'(ifF.oBusy), 0);
        chk("rst_rdata", 48'(ifF.oRData), 0);
        rst = 1'b0;
        step();

        // single read, port 1
        req = 3'b010; addr[16 +: 16] = 16'h8000; memRData = 8'h5A;
        step();
        req = '0;
        chk("rd_memreq", 48'(ifF.oMemReq), 1);
        chk("rd_memaddr", 48'(ifF.oMemAddr), 48'h8000);
        chk("rd_memwe", 48'(ifF.oMemWe), 0);
        chk("rd_grant", 48'(ifF.oGrant), 48'b010);
        chk("rd_busy", 48'(ifF.oBusy), 1);
        chk("rd_grant_rr", 48'(ifR.oGrant), 48'b010);
        step();
        chk("rd_memreq_1cyc", 48'(ifF.oMemReq), 0);
        chk("rd_ack_early", 48'(ifF.oAck), 0);
        step();
        chk("rd_ack", 48'(ifF.oAck), 48'b010);
        chk("rd_rdata", 48'(ifF.oRData), 48'h5A);
        step();
        chk("rd_ack_done", 48'(ifF.oAck), 0);
        chk("rd_busy_done", 48'(ifF.oBusy), 0);
        chk("rd_grant_done", 48'(ifF.oGrant), 0);
        repeat (4) step();

        // single write, port 2
        req = 3'b100; we = 3'b100; addr[32 +: 16] = 16'hFF40; wdata[16 +: 8] = 8'h91;
        memRData = 8'h33;
        step();
        req = '0;
        chk("wr_memreq", 48'(ifF.oMemReq), 1);
        chk("wr_memwe", 48'(ifF.oMemWe), 1);
        chk("wr_wdata", 48'(ifF.oMemWData), 48'h91);
        chk("wr_memaddr", 48'(ifF.oMemAddr), 48'hFF40);
        chk("wr_grant", 48'(ifF.oGrant), 48'b100);
        step(); step();
        chk("wr_ack", 48'(ifF.oAck), 48'b100);
        chk("wr_rdata_hold", 48'(ifF.oRData), 48'h5A);
        we = '0;
        repeat (5) step();

        // all three ports held: fixed always picks 0, round-robin rotates 0,1,2
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fp_grant", 48'(ifF.oGrant), 48'b001);
            chk("rr_grant", 48'(ifR.oGrant), 48'(3'b001 << (k % 3)));
            chk("rr_memreq", 48'(ifR.oMemReq), 1);
            step();
            chk("rr_memreq_gap", 48'(ifR.oMemReq), 0);
            step();
            chk("fp_ack", 48'(ifF.oAck), 48'b001);
            chk("rr_ack", 48'(ifR.oAck), 48'(3'b001 << (k % 3)));
            step();
            chk("rr_idle_slot", 48'(ifR.oBusy), 0);
        end
        req = '0;
        repeat (8) step();

        // latency 3 read on port 0: capture the data present on the capture edge
        req = 3'b001; addr[0 +: 16] = 16'h1234; memRData = 8'h00;
        step();
        req = '0;
        chk("l3_grant", 48'(ifL.oGrant), 48'b001);
        chk("l3_memreq", 48'(ifL.oMemReq), 1);
        chk("l3_memaddr", 48'(ifL.oMemAddr), 48'h1234);
        memRData = 8'hA1;
        step();
        memRData = 8'hA2;
        step();
        chk("l1_capture", 48'(ifF.oRData), 48'hA2);
        memRData = 8'hA3;
        step();
        chk("l3_ack_early", 48'(ifL.oAck), 0);
        memRData = 8'hC3;
        step();
        chk("l3_ack", 48'(ifL.oAck), 48'b001);
        chk("l3_rdata", 48'(ifL.oRData), 48'hC3);
        memRData = 8'hEE;
        step();
        chk("l3_ack_done", 48'(ifL.oAck), 0);
        chk("l3_busy_done", 48'(ifL.oBusy), 0);
        chk("l3_rdata_hold", 48'(ifL.oRData), 48'hC3);
        repeat (2) step();

        // reset while round-robin arbiter is in WAIT
        req = 3'b100;
        step();
        req = '0;
        chk("mid_grant", 48'(ifR.oGrant), 48'b100);
        step();
        rst = 1'b1;
        #1;
        chk("async_grant", 48'(ifR.oGrant), 0);
        chk("async_memreq", 48'(ifR.oMemReq), 0);
        chk("async_busy", 48'(ifR.oBusy), 0);
        chk("async_memaddr", 48'(ifR.oMemAddr), 0);
        chk("async_rdata", 48'(ifR.oRData), 0);
        chk("async_ack", 48'(ifR.oAck), 0);
        step(); step();
        chk("no_ack_after_rst", 48'(ifR.oAck), 0);
        rst = 1'b0;
        req = 3'b010;
        step();
        chk("post_rst_grant", 48'(ifR.oGrant), 48'b010);
        req = 3'b111;
        step(); step();
        chk("post_rst_ack", 48'(ifR.oAck), 48'b010);
        step(); step();
        chk("post_rst_next", 48'(ifR.oGrant), 48'b100);
        req = '0;
        repeat (8) step();

        // fresh reset leaves port 0 at the head of the round-robin order
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 3'b111;
        step();
        chk("rst_ptr_grant", 48'(ifR.oGrant), 48'b001);
        req = '0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
